// File: rtl/pwm_fade_sequencer.sv
// pwm_fade_sequencer
// Generates single-clock step pulses for an adjustable_pwm instance: ramp the
// duty up or down once, breathe continuously, or pass debounced manual button
// steps through. A shadow copy of the PWM duty keeps the controller from ever
// stepping past 0 or the maximum duty.
module pwm_fade_sequencer #(
    parameter int CNTR_LEN    = 4,
    parameter int STEP_DIV    = 1000,
    parameter int DWELL_TICKS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_enable,
    input  logic [1:0]          i_mode,
    input  logic                i_btn_up,
    input  logic                i_btn_down,
    output logic                o_cycle_up,
    output logic                o_cycle_down,
    output logic [CNTR_LEN-1:0] o_duty,
    output logic                o_busy,
    output logic [2:0]          o_state
);

    localparam int PRE_W   = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int DWELL_W = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;

    localparam logic [PRE_W-1:0]    PRE_LAST   = PRE_W'(STEP_DIV - 1);
    localparam logic [DWELL_W-1:0]  DWELL_LAST = DWELL_W'(DWELL_TICKS - 1);
    localparam logic [CNTR_LEN-1:0] DUTY_MAX   = '1;
    localparam logic [CNTR_LEN-1:0] DUTY_PEN   = DUTY_MAX - CNTR_LEN'(1);
    localparam logic [CNTR_LEN-1:0] DUTY_ONE   = CNTR_LEN'(1);

    localparam logic [1:0] MODE_MANUAL  = 2'b00;
    localparam logic [1:0] MODE_UP      = 2'b01;
    localparam logic [1:0] MODE_DOWN    = 2'b10;
    localparam logic [1:0] MODE_BREATHE = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RAMP_UP   = 3'd1,
        ST_DWELL_TOP = 3'd2,
        ST_RAMP_DOWN = 3'd3,
        ST_DWELL_BOT = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [1:0]            r_mode;
    logic [PRE_W-1:0]      r_presc;
    logic [DWELL_W-1:0]    r_dwell;
    logic                  r_btn_up_q;
    logic                  r_btn_up_qq;
    logic                  r_btn_dn_q;
    logic                  r_btn_dn_qq;
    logic                  r_cycle_up;
    logic                  r_cycle_down;
    logic [CNTR_LEN-1:0]   r_duty;
    logic                  r_busy;

    logic                  w_tick;
    logic                  w_abort;
    logic                  w_up_edge;
    logic                  w_dn_edge;
    logic                  w_at_max;
    logic                  w_at_zero;
    logic                  w_manual;
    logic                  w_state_change;
    logic                  w_fire_up;
    logic                  w_fire_dn;

    assign w_tick         = (r_presc == PRE_LAST);
    assign w_abort        = !i_enable || (i_mode != r_mode);
    assign w_up_edge      = r_btn_up_q && !r_btn_up_qq;
    assign w_dn_edge      = r_btn_dn_q && !r_btn_dn_qq;
    assign w_at_max       = (r_duty == DUTY_MAX);
    assign w_at_zero      = (r_duty == '0);
    assign w_manual       = !i_enable || (i_mode == MODE_MANUAL);
    assign w_state_change = (w_next_state != r_state);

    // State register.
    // NOTE: every clocked process uses non-blocking assignments so all
    // registers update from the same pre-edge values, as real flops do.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and step-pulse decisions.
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_fire_up    = 1'b0;
        w_fire_dn    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_enable && (i_mode == MODE_UP) && !w_at_max) begin
                    w_next_state = ST_RAMP_UP;
                end else if (i_enable && (i_mode == MODE_DOWN) && !w_at_zero) begin
                    w_next_state = ST_RAMP_DOWN;
                end else if (i_enable && (i_mode == MODE_BREATHE)) begin
                    w_next_state = w_at_max ? ST_DWELL_TOP : ST_RAMP_UP;
                end else if (w_manual) begin
                    // Simultaneous edges cancel; saturation suppresses the step.
                    if (w_up_edge && !w_dn_edge && !w_at_max) begin
                        w_fire_up = 1'b1;
                    end else if (w_dn_edge && !w_up_edge && !w_at_zero) begin
                        w_fire_dn = 1'b1;
                    end
                end
            end
            ST_RAMP_UP: begin
                if (w_abort) begin
                    w_next_state = ST_IDLE;
                end else if (w_at_max) begin
                    // Entered already at the top: move on without a pulse.
                    w_next_state = (r_mode == MODE_BREATHE) ? ST_DWELL_TOP : ST_IDLE;
                end else if (w_tick) begin
                    w_fire_up = 1'b1;
                    if (r_duty == DUTY_PEN) begin
                        w_next_state = (r_mode == MODE_BREATHE) ? ST_DWELL_TOP : ST_IDLE;
                    end
                end
            end
            ST_RAMP_DOWN: begin
                if (w_abort) begin
                    w_next_state = ST_IDLE;
                end else if (w_at_zero) begin
                    w_next_state = (r_mode == MODE_BREATHE) ? ST_DWELL_BOT : ST_IDLE;
                end else if (w_tick) begin
                    w_fire_dn = 1'b1;
                    if (r_duty == DUTY_ONE) begin
                        w_next_state = (r_mode == MODE_BREATHE) ? ST_DWELL_BOT : ST_IDLE;
                    end
                end
            end
            ST_DWELL_TOP: begin
                if (w_abort) begin
                    w_next_state = ST_IDLE;
                end else if (w_tick && (r_dwell == DWELL_LAST)) begin
                    w_next_state = ST_RAMP_DOWN;
                end
            end
            ST_DWELL_BOT: begin
                if (w_abort) begin
                    w_next_state = ST_IDLE;
                end else if (w_tick && (r_dwell == DWELL_LAST)) begin
                    w_next_state = ST_RAMP_UP;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Step prescaler: idle-held at zero, restarted on every state entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_presc <= '0;
        end else if (w_state_change || (r_state == ST_IDLE) || w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PRE_W'(1);
        end
    end

    // Dwell tick counter for the top/bottom hold in breathe mode.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dwell <= '0;
        end else if (w_state_change) begin
            r_dwell <= '0;
        end else if (w_tick && ((r_state == ST_DWELL_TOP) || (r_state == ST_DWELL_BOT))) begin
            r_dwell <= r_dwell + DWELL_W'(1);
        end
    end

    // Mode snapshot taken while idle; any later change aborts the sequence.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mode <= MODE_MANUAL;
        end else if (r_state == ST_IDLE) begin
            r_mode <= i_mode;
        end
    end

    // Button edge detectors track continuously so no stale edge survives a ramp.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_btn_up_q  <= 1'b0;
            r_btn_up_qq <= 1'b0;
            r_btn_dn_q  <= 1'b0;
            r_btn_dn_qq <= 1'b0;
        end else begin
            r_btn_up_q  <= i_btn_up;
            r_btn_up_qq <= r_btn_up_q;
            r_btn_dn_q  <= i_btn_down;
            r_btn_dn_qq <= r_btn_dn_q;
        end
    end

    // Registered pulses, shadow duty and busy flag, all updated on one edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cycle_up   <= 1'b0;
            r_cycle_down <= 1'b0;
            r_duty       <= '0;
            r_busy       <= 1'b0;
        end else begin
            r_cycle_up   <= w_fire_up;
            r_cycle_down <= w_fire_dn;
            r_busy       <= (w_next_state != ST_IDLE);
            if (w_fire_up) begin
                r_duty <= r_duty + CNTR_LEN'(1);
            end else if (w_fire_dn) begin
                r_duty <= r_duty - CNTR_LEN'(1);
            end
        end
    end

    assign o_cycle_up   = r_cycle_up;
    assign o_cycle_down = r_cycle_down;
    assign o_duty       = r_duty;
    assign o_busy       = r_busy;
    assign o_state      = r_state;

endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// Bench for pwm_fade_sequencer with CNTR_LEN=4, STEP_DIV=4, DWELL_TICKS=2.
// A reference duty counter follows the step pulses like the downstream PWM
// would; a queue holds the expected direction, duty and spacing of each pulse.
module tb_pwm_fade_sequencer;

    localparam int CL   = 4;
    localparam int SD   = 4;
    localparam int DT   = 2;
    localparam int DMAX = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_enable = 1'b0;
    logic [1:0]    i_mode = 2'b00;
    logic          i_btn_up = 1'b0;
    logic          i_btn_down = 1'b0;
    logic          o_cycle_up;
    logic          o_cycle_down;
    logic [CL-1:0] o_duty;
    logic          o_busy;
    logic [2:0]    o_state;

    pwm_fade_sequencer #(.CNTR_LEN(CL), .STEP_DIV(SD), .DWELL_TICKS(DT)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_enable     (i_enable),
        .i_mode       (i_mode),
        .i_btn_up     (i_btn_up),
        .i_btn_down   (i_btn_down),
        .o_cycle_up   (o_cycle_up),
        .o_cycle_down (o_cycle_down),
        .o_duty       (o_duty),
        .o_busy       (o_busy),
        .o_state      (o_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit up;
        int duty;
        int gap;
    } exp_t;

    typedef struct {
        bit         en;
        logic [1:0] mode;
        int         n;
        int         ups;
        int         dns;
        int         duty;
        int         state;
        bit         busy;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[8];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   mark_cyc = 0;
    int   n_up = 0;
    int   n_dn = 0;
    int   model_duty = 0;
    bit   sb_active = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    // Reference duty model and scoreboard consumer.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst) begin
            model_duty = 0;
        end else begin
            check("one_pulse_only", {31'd0, o_cycle_up & o_cycle_down}, 32'd0);
            if (o_cycle_up) begin
                check("no_up_at_max", {31'd0, model_duty < DMAX}, 32'd1);
                model_duty++;
                n_up++;
            end
            if (o_cycle_down) begin
                check("no_down_at_zero", {31'd0, model_duty > 0}, 32'd1);
                model_duty--;
                n_dn++;
            end
            if (o_cycle_up || o_cycle_down) begin
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check("sb_dir", {31'd0, o_cycle_up}, {31'd0, e.up});
                    check("sb_duty", o_duty, e.duty);
                    check("sb_gap", cyc - mark_cyc, e.gap);
                end else if (sb_active) begin
                    check("unexpected_pulse", {31'd0, o_cycle_up}, {31'd0, o_cycle_down});
                    failures++;
                    $display("FAIL unexpected_pulse: up=%0d down=%0d duty=%0d", o_cycle_up, o_cycle_down, o_duty);
                end
                mark_cyc = cyc;
            end
            check("pwm_model_duty", o_duty, model_duty);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        i_enable = 1'b0;
        i_mode = 2'b00;
        i_btn_up = 1'b0;
        i_btn_down = 1'b0;
        sb_q.delete();
        step(2);
        rst = 1'b1;
        step(1);
        n_up = 0;
        n_dn = 0;
    endtask

    task automatic push(input bit up, input int duty, input int gap);
        exp_t e;
        e.up = up;
        e.duty = duty;
        e.gap = gap;
        sb_q.push_back(e);
    endtask

    task automatic wait_sb(input int budget, input string name);
        int n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            step(1);
            n++;
        end
        check(name, sb_q.size(), 32'd0);
        sb_q.delete();
    endtask

    task automatic wait_duty(input int target, input int budget, input string name);
        int n = 0;
        while (o_duty != target && n < budget) begin
            step(1);
            n++;
        end
        check(name, o_duty, target);
    endtask

    task automatic press(input bit up, input bit dn);
        i_btn_up = up;
        i_btn_down = dn;
        mark_cyc = cyc;
        step(3);
        i_btn_up = 1'b0;
        i_btn_down = 1'b0;
        step(3);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int snap;
        // {en, mode, edges, ups, downs, duty, state, busy}, each from reset (duty 0).
        vecs[0] = '{1'b1, 2'b01,  40,  9,  0,  9, 1, 1'b1};
        vecs[1] = '{1'b1, 2'b01,  70, 15,  0, 15, 0, 1'b0};
        vecs[2] = '{1'b1, 2'b10,  20,  0,  0,  0, 0, 1'b0};
        vecs[3] = '{1'b0, 2'b11,  20,  0,  0,  0, 0, 1'b0};
        vecs[4] = '{1'b1, 2'b11,  66, 15,  0, 15, 2, 1'b1};
        vecs[5] = '{1'b1, 2'b11, 100, 15,  7,  8, 3, 1'b1};
        vecs[6] = '{1'b1, 2'b11, 138, 15, 15,  0, 1, 1'b1};
        vecs[7] = '{1'b1, 2'b00,  20,  0,  0,  0, 0, 1'b0};

        // Async reset asserted mid-ramp clears everything without a clock edge.
        do_reset();
        i_enable = 1'b1;
        i_mode = 2'b01;
        wait_duty(5, 100, "rst_pre_ramp");
        rst = 1'b0;
        #1;
        check("rst_async_duty", o_duty, 32'd0);
        check("rst_async_up", {31'd0, o_cycle_up}, 32'd0);
        check("rst_async_down", {31'd0, o_cycle_down}, 32'd0);
        check("rst_async_state", o_state, 32'd0);
        check("rst_async_busy", {31'd0, o_busy}, 32'd0);
        i_enable = 1'b0;
        step(2);
        rst = 1'b1;
        n_up = 0;
        n_dn = 0;
        step(20);
        settle();
        check("rst_quiet_up", n_up, 32'd0);
        check("rst_quiet_down", n_dn, 32'd0);
        check("rst_quiet_state", o_state, 32'd0);

        // Table-driven mode runs.
        for (int i = 0; i < 8; i++) begin
            do_reset();
            i_enable = vecs[i].en;
            i_mode = vecs[i].mode;
            step(vecs[i].n);
            settle();
            check($sformatf("vec%0d_ups", i), n_up, vecs[i].ups);
            check($sformatf("vec%0d_downs", i), n_dn, vecs[i].dns);
            check($sformatf("vec%0d_duty", i), o_duty, vecs[i].duty);
            check($sformatf("vec%0d_state", i), o_state, vecs[i].state);
            check($sformatf("vec%0d_busy", i), {31'd0, o_busy}, {31'd0, vecs[i].busy});
        end

        // Ramp up once: 15 pulses, first on the 4th edge after entry, then every 4.
        do_reset();
        sb_active = 1'b1;
        for (int k = 1; k <= DMAX; k++) push(1'b1, k, (k == 1) ? SD + 1 : SD);
        i_enable = 1'b1;
        i_mode = 2'b01;
        mark_cyc = cyc;
        wait_sb(150, "ramp_up_done");
        check("ramp_up_state", o_state, 32'd0);
        check("ramp_up_busy", {31'd0, o_busy}, 32'd0);
        check("ramp_up_duty", o_duty, 32'd15);
        snap = n_up;
        step(20);
        settle();
        check("ramp_up_hold", n_up, snap);

        // Manual steps: down at zero ignored, 17 ups saturate at 15, both edges cancel.
        do_reset();
        i_enable = 1'b1;
        i_mode = 2'b00;
        press(1'b0, 1'b1);
        check("man_down_at_zero", n_dn, 32'd0);
        for (int k = 1; k <= 17; k++) begin
            if (k <= DMAX) push(1'b1, k, 2);
            press(1'b1, 1'b0);
        end
        check("man_up_count", n_up, 32'd15);
        check("man_up_duty", o_duty, 32'd15);
        press(1'b1, 1'b1);
        check("man_both_up", n_up, 32'd15);
        check("man_both_down", n_dn, 32'd0);
        push(1'b0, 14, 2);
        press(1'b0, 1'b1);
        wait_sb(10, "man_down_done");
        check("man_down_duty", o_duty, 32'd14);

        // Abort by dropping enable at duty 7.
        do_reset();
        for (int k = 1; k <= 7; k++) push(1'b1, k, (k == 1) ? SD + 1 : SD);
        i_enable = 1'b1;
        i_mode = 2'b11;
        mark_cyc = cyc;
        wait_duty(7, 100, "abort_reach7");
        i_enable = 1'b0;
        step(1);
        check("abort_en_state", o_state, 32'd0);
        check("abort_en_busy", {31'd0, o_busy}, 32'd0);
        snap = n_up;
        step(12);
        settle();
        check("abort_en_nopulse", n_up, snap);
        check("abort_en_duty", o_duty, 32'd7);

        // Abort by changing mode mid-ramp; a button held through the ramp stays silent.
        for (int k = 8; k <= 10; k++) push(1'b1, k, (k == 8) ? SD + 1 : SD);
        i_enable = 1'b1;
        mark_cyc = cyc;
        step(1);
        i_btn_up = 1'b1;
        wait_duty(10, 100, "abort_reach10");
        i_mode = 2'b00;
        step(1);
        check("abort_mode_state", o_state, 32'd0);
        snap = n_up;
        step(12);
        settle();
        check("abort_mode_nopulse", n_up, snap);
        check("abort_mode_duty", o_duty, 32'd10);
        check("abort_sb_empty", sb_q.size(), 32'd0);
        i_btn_up = 1'b0;

        // Breathe for 10 periods of 136 clocks.
        do_reset();
        for (int p = 0; p < 10; p++) begin
            for (int k = 1; k <= DMAX; k++)
                push(1'b1, k, (k == 1) ? ((p == 0) ? SD + 1 : SD * (DT + 1)) : SD);
            for (int k = 1; k <= DMAX; k++)
                push(1'b0, DMAX - k, (k == 1) ? SD * (DT + 1) : SD);
        end
        i_enable = 1'b1;
        i_mode = 2'b11;
        mark_cyc = cyc;
        wait_sb(10 * 136 + 50, "breathe_done");
        check("breathe_state", o_state, 32'd4);
        check("breathe_busy", {31'd0, o_busy}, 32'd1);
        check("breathe_duty", o_duty, 32'd0);
        check("breathe_ups", n_up, 32'd150);
        check("breathe_downs", n_dn, 32'd150);

        sb_active = 1'b0;
        i_enable = 1'b0;
        step(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
